// File: rtl/multichannel_data_loader_pkg.sv
// rtl/multichannel_data_loader_pkg.sv - shared FSM encodings for the sample loader
// Purpose: state type used by the loader FSM.
// Contents: STATE_W, state_e (S_IDLE=0, S_LOAD=1, S_LOADED=2, S_REPLAY=3).
package multichannel_data_loader_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_LOADED = 2'd2,
    S_REPLAY = 2'd3
  } state_e;

endpackage

// File: rtl/multichannel_data_loader_if.sv
// rtl/multichannel_data_loader_if.sv - control, stream and status bundle of the loader
// Purpose: groups the control pulses, input stream, replay stream and status signals.
// master: source/consumer side (drives start/replay/abort, in_*, out_ready).
// slave : the loader (drives in_ready, out_*, count, loaded, busy).
interface multichannel_data_loader_if #(
  parameter int WORD_W   = 20,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 150
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                       start;
  logic                       replay;
  logic                       abort;
  logic                       in_valid;
  logic                       in_ready;
  logic [CHANNELS*WORD_W-1:0] in_data;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [CHANNELS*WORD_W-1:0] out_data;
  logic                       out_last;
  logic [ADDR_W:0]            count;
  logic                       loaded;
  logic                       busy;

  modport master (
    output start, replay, abort, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, count, loaded, busy
  );

  modport slave (
    input  start, replay, abort, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, count, loaded, busy
  );
endinterface

// File: rtl/multichannel_data_loader_mem.sv
// rtl/multichannel_data_loader_mem.sv - one channel of sample storage
// Purpose: WORD_W x DEPTH RAM, synchronous write, asynchronous read, no reset.
// Ports: clk, we_i, addr_i, wdata_i, rdata_o.
module loader_mem #(
  parameter int WORD_W = 20,
  parameter int DEPTH  = 150,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/multichannel_data_loader.sv
// rtl/multichannel_data_loader.sv - sample buffer: load up to DEPTH beats, replay many times
// Purpose: captures a handshaked multi-channel stream, then replays it per epoch.
// Ports: clk, rst (async active-low), bus (slave modport: control pulses,
//        input stream, replay stream, count/loaded/busy status).
module multichannel_data_loader
  import multichannel_data_loader_pkg::*;
#(
  parameter  int WORD_W   = 20,
  parameter  int CHANNELS = 2,
  parameter  int DEPTH    = 150,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  multichannel_data_loader_if.slave   bus
);
  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]            count_q, count_d;
  logic                       in_ready_q, out_valid_q, loaded_q, busy_q;
  logic                       in_fire, out_fire, out_last_w;
  logic [ADDR_W-1:0]          addr;
  logic [CHANNELS*WORD_W-1:0] rdata;

  assign in_fire    = in_ready_q & bus.in_valid;
  assign out_fire   = out_valid_q & bus.out_ready;
  assign out_last_w = out_valid_q & ({1'b0, rd_ptr_q} == count_q - (ADDR_W+1)'(1));

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d  = S_LOAD;
        wr_ptr_d = '0;
        count_d  = '0;
      end
      S_LOAD: if (in_fire) begin
        // Terminal beat: pointer stays put so it never passes DEPTH-1.
        if (bus.in_last || wr_ptr_q == ADDR_W'(DEPTH-1)) begin
          state_d = S_LOADED;
          count_d = {1'b0, wr_ptr_q} + (ADDR_W+1)'(1);
        end else begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
      end
      S_LOADED: if (bus.replay) begin
        state_d  = S_REPLAY;
        rd_ptr_d = '0;
      end else if (bus.start) begin
        state_d  = S_LOAD;
        wr_ptr_d = '0;
        count_d  = '0;
      end
      S_REPLAY: if (out_fire) begin
        if (out_last_w) state_d = S_LOADED;
        else            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.abort) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      loaded_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= (state_d == S_LOAD);
      out_valid_q <= (state_d == S_REPLAY);
      loaded_q    <= (state_d == S_LOADED) || (state_d == S_REPLAY);
      busy_q      <= (state_d == S_LOAD) || (state_d == S_REPLAY);
    end
  end

  assign addr = (state_q == S_LOAD) ? wr_ptr_q : rd_ptr_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    loader_mem #(.WORD_W(WORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
      .clk     (clk),
      .we_i    (in_fire),
      .addr_i  (addr),
      .wdata_i (bus.in_data[c*WORD_W +: WORD_W]),
      .rdata_o (rdata[c*WORD_W +: WORD_W])
    );
  end

  // RAM is not reset, so gate the read data to keep outputs at 0 outside replay.
  assign bus.out_data  = out_valid_q ? rdata : '0;
  assign bus.out_last  = out_last_w;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.count     = count_q;
  assign bus.loaded    = loaded_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_multichannel_data_loader.sv
// tb/tb_multichannel_data_loader.sv - directed self-checking bench for multichannel_data_loader
module tb_multichannel_data_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multichannel_data_loader_if #(.WORD_W(20), .CHANNELS(2), .DEPTH(150)) bus ();
  multichannel_data_loader #(.WORD_W(20), .CHANNELS(2), .DEPTH(150)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Drives n beats x=xb+xs*i, y=yb+ys*i; a gap cycle before every beat with i%gap==1.
  task automatic load_beats(input int n, input int xb, input int xs, input int yb, input int ys,
                            input bit use_last, input int gap);
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && i % gap == 1) begin
        bus.in_valid = 1'b0;
        step();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = {20'(yb + ys*i), 20'(xb + xs*i)};
      bus.in_last  = use_last && (i == n-1);
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Replays and checks every beat; out_ready is low on cycles where cyc%stall==0.
  task automatic replay_check(input string tag, input int n, input int xb, input int xs,
                              input int yb, input int ys, input int stall);
    int idx = 0;
    bus.replay = 1'b1;
    step();
    bus.replay = 1'b0;
    for (int cyc = 0; cyc < 4*n + 10 && idx < n; cyc++) begin
      check({tag, "_data"}, 64'(bus.out_data), 64'({20'(yb + ys*idx), 20'(xb + xs*idx)}));
      check({tag, "_last"}, 64'(bus.out_last), 64'(idx == n-1));
      bus.out_ready = !(stall > 0 && cyc % stall == 0);
      step();
      if (bus.out_ready) idx++;
    end
    bus.out_ready = 1'b0;
    check({tag, "_beats"}, 64'(idx), 64'(n));
    check({tag, "_done_valid"}, 64'(bus.out_valid), 64'h0);
    check({tag, "_count"}, 64'(bus.count), 64'(n));
    check({tag, "_loaded"}, 64'(bus.loaded), 64'h1);
  endtask

  initial begin
    bus.start = 0; bus.replay = 0; bus.abort = 0;
    bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.out_ready = 0;
    step(); step();
    check("rst_in_ready", 64'(bus.in_ready), 64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_out_data", 64'(bus.out_data), 64'h0);
    check("rst_out_last", 64'(bus.out_last), 64'h0);
    check("rst_count", 64'(bus.count), 64'h0);
    check("rst_loaded", 64'(bus.loaded), 64'h0);
    check("rst_busy", 64'(bus.busy), 64'h0);
    rst = 1'b1;
    step();

    // 1: full load, terminated by depth
    start_load();
    check("t1_in_ready", 64'(bus.in_ready), 64'h1);
    load_beats(149, 0, 1, 1000, 1, 1'b0, 0);
    check("t1_still_load", 64'(bus.in_ready), 64'h1);
    bus.in_valid = 1'b1; bus.in_data = {20'd1149, 20'd149};
    step();
    bus.in_valid = 1'b0;
    check("t1_count", 64'(bus.count), 64'd150);
    check("t1_in_ready_off", 64'(bus.in_ready), 64'h0);
    check("t1_loaded", 64'(bus.loaded), 64'h1);
    replay_check("t1_rep", 150, 0, 1, 1000, 1, 0);

    // 2: early end with in_last
    start_load();
    load_beats(5, 0, 1, 500, 1, 1'b1, 0);
    check("t2_count", 64'(bus.count), 64'd5);
    replay_check("t2_rep", 5, 0, 1, 500, 1, 0);

    // 3: backpressure; beat held while in_ready=0 must not be written early
    bus.in_valid = 1'b1; bus.in_data = {20'd300, 20'd100};
    step();
    start_load();
    load_beats(10, 100, 1, 300, 2, 1'b1, 3);
    check("t3_count", 64'(bus.count), 64'd10);
    replay_check("t3_rep", 10, 100, 1, 300, 2, 3);

    // 4: multi-epoch replay
    start_load();
    load_beats(8, 0, 3, 0, 7, 1'b1, 0);
    for (int e = 0; e < 3; e++) replay_check("t4_rep", 8, 0, 3, 0, 7, 0);

    // 5: replay wins over start; abort mid-replay; replay ignored in IDLE
    bus.start = 1'b1; bus.replay = 1'b1;
    step();
    bus.start = 1'b0; bus.replay = 1'b0;
    check("t5_both_valid", 64'(bus.out_valid), 64'h1);
    check("t5_both_in_ready", 64'(bus.in_ready), 64'h0);
    bus.out_ready = 1'b1;
    step(); step(); step();
    check("t5_beat3", 64'(bus.out_data), 64'({20'd21, 20'd9}));
    bus.abort = 1'b1; bus.out_ready = 1'b0;
    step();
    bus.abort = 1'b0;
    check("t5_abort_valid", 64'(bus.out_valid), 64'h0);
    check("t5_abort_count", 64'(bus.count), 64'h0);
    check("t5_abort_loaded", 64'(bus.loaded), 64'h0);
    check("t5_abort_busy", 64'(bus.busy), 64'h0);
    bus.replay = 1'b1;
    step();
    bus.replay = 1'b0;
    check("t5_idle_replay", 64'(bus.out_valid), 64'h0);
    start_load();
    load_beats(2, 40, 1, 60, 1, 1'b0, 0);
    bus.start = 1'b1;
    load_beats(2, 42, 1, 62, 1, 1'b1, 0);
    bus.start = 1'b0;
    check("t5_start_in_load", 64'(bus.count), 64'd4);
    replay_check("t5_rep", 4, 40, 1, 60, 1, 0);

    // 6: asynchronous reset mid-load, then a fresh load
    start_load();
    load_beats(7, 0, 1, 0, 1, 1'b0, 0);
    check("t6_pre_busy", 64'(bus.busy), 64'h1);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_in_ready", 64'(bus.in_ready), 64'h0);
    check("t6_rst_busy", 64'(bus.busy), 64'h0);
    check("t6_rst_count", 64'(bus.count), 64'h0);
    step();
    rst = 1'b1;
    step();
    start_load();
    load_beats(4, 70, 2, 90, 2, 1'b1, 0);
    check("t6_count", 64'(bus.count), 64'd4);
    replay_check("t6_rep", 4, 70, 2, 90, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
